// File: rtl/html_tokenizer.sv
// html_tokenizer: turns a raw page character stream into TEXT / OPEN / CLOSE / END
// tokens. Whitespace runs collapse to one space, tag names are lower-cased and
// truncated to MAX_TAG characters, attributes and <!...> constructs are skipped.
module html_tokenizer #(
    parameter int MAX_TAG = 8
) (
    input  logic                   clock,
    input  logic                   state_enable,
    input  logic [7:0]             char,
    input  logic                   char_valid,
    output logic                   char_ready,
    input  logic                   in_done,
    output logic                   tok_valid,
    input  logic                   tok_ready,
    output logic [1:0]             tok_type,
    output logic [7:0]             tok_char,
    output logic [8*MAX_TAG-1:0]   tag_name,
    output logic [3:0]             tag_len,
    output logic                   tag_trunc,
    output logic                   tag_self
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_TAG);

    localparam logic [1:0] T_TEXT  = 2'd0;
    localparam logic [1:0] T_OPEN  = 2'd1;
    localparam logic [1:0] T_CLOSE = 2'd2;
    localparam logic [1:0] T_END   = 2'd3;

    localparam logic [7:0] C_LT    = 8'h3C;
    localparam logic [7:0] C_GT    = 8'h3E;
    localparam logic [7:0] C_SLASH = 8'h2F;
    localparam logic [7:0] C_BANG  = 8'h21;
    localparam logic [7:0] C_SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_TEXT,
        S_LT,
        S_NAME,
        S_ATTR,
        S_SKIP,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic                 ws_seen_reg, ws_seen_next;
    logic                 close_reg, close_next;
    logic                 slash_reg, slash_next;
    logic [8*MAX_TAG-1:0] name_buf_reg, name_buf_next;
    logic [3:0]           name_len_reg, name_len_next;
    logic                 trunc_reg, trunc_next;
    // A character seen in LT that does not start a tag is parked here and
    // re-processed as ordinary text once the '<' token has gone out.
    logic                 hold_valid_reg, hold_valid_next;
    logic [7:0]           hold_char_reg, hold_char_next;

    logic                 tok_valid_reg, tok_valid_next;
    logic [1:0]           tok_type_reg, tok_type_next;
    logic [7:0]           tok_char_reg, tok_char_next;
    logic [8*MAX_TAG-1:0] tag_name_reg, tag_name_next;
    logic [3:0]           tag_len_reg, tag_len_next;
    logic                 tag_trunc_reg, tag_trunc_next;
    logic                 tag_self_reg, tag_self_next;

    logic                 active;
    logic                 accept;
    logic                 use_hold;
    logic                 cur_valid;
    logic [7:0]           cur;
    logic                 cur_null;
    logic                 cur_ws;
    logic                 cur_upper;
    logic                 cur_letter;
    logic                 cur_namech;
    logic [7:0]           cur_lc;
    logic [MAX_TAG-1:0]   byte_sel;

    logic                 do_text;
    logic [7:0]           text_char;
    logic                 do_tag;
    logic                 do_end;
    logic                 append;

    assign active     = (state_reg inside {S_TEXT, S_LT, S_NAME, S_ATTR, S_SKIP});
    assign char_ready = state_enable && !tok_valid_reg && !hold_valid_reg && active;
    assign accept     = char_valid && char_ready;
    assign use_hold   = hold_valid_reg && !tok_valid_reg && (state_reg == S_TEXT);
    assign cur_valid  = accept || use_hold;
    assign cur        = use_hold ? hold_char_reg : char;

    assign cur_null   = (cur == 8'h00) || (cur == 8'hFF);
    assign cur_ws     = (cur == 8'h20) || (cur == 8'h09) || (cur == 8'h0A) || (cur == 8'h0D);
    assign cur_upper  = (cur >= 8'h41) && (cur <= 8'h5A);
    assign cur_letter = cur_upper || ((cur >= 8'h61) && (cur <= 8'h7A));
    assign cur_namech = cur_letter || ((cur >= 8'h30) && (cur <= 8'h39)) || (cur == 8'h2D);
    assign cur_lc     = cur_upper ? (cur + 8'h20) : cur;

    // One-hot select of the name byte that the next appended character lands in.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_TAG; gi++) begin : g_sel
            assign byte_sel[gi] = (name_len_reg == 4'(gi));
        end
    endgenerate

    // Next-state, tag assembly and token generation.
    always_comb begin
        state_next      = state_reg;
        ws_seen_next    = ws_seen_reg;
        close_next      = close_reg;
        slash_next      = slash_reg;
        name_buf_next   = name_buf_reg;
        name_len_next   = name_len_reg;
        trunc_next      = trunc_reg;
        hold_valid_next = hold_valid_reg;
        hold_char_next  = hold_char_reg;

        tok_valid_next  = tok_valid_reg && !tok_ready;
        tok_type_next   = tok_type_reg;
        tok_char_next   = tok_char_reg;
        tag_name_next   = tag_name_reg;
        tag_len_next    = tag_len_reg;
        tag_trunc_next  = tag_trunc_reg;
        tag_self_next   = tag_self_reg;

        do_text   = 1'b0;
        text_char = 8'h00;
        do_tag    = 1'b0;
        do_end    = 1'b0;
        append    = 1'b0;

        if (use_hold) begin
            hold_valid_next = 1'b0;
        end

        if (cur_valid && !cur_null) begin
            case (state_reg)
                S_TEXT: begin
                    if (cur == C_LT) begin
                        state_next    = S_LT;
                        close_next    = 1'b0;
                        slash_next    = 1'b0;
                        name_buf_next = '0;
                        name_len_next = 4'd0;
                        trunc_next    = 1'b0;
                    end else if (cur_ws) begin
                        if (!ws_seen_reg) begin
                            do_text      = 1'b1;
                            text_char    = C_SPACE;
                            ws_seen_next = 1'b1;
                        end
                    end else begin
                        do_text      = 1'b1;
                        text_char    = cur;
                        ws_seen_next = 1'b0;
                    end
                end
                S_LT: begin
                    if (cur == C_SLASH) begin
                        state_next = S_NAME;
                        close_next = 1'b1;
                    end else if (cur_letter) begin
                        state_next = S_NAME;
                        append     = 1'b1;
                    end else if (cur == C_BANG) begin
                        state_next = S_SKIP;
                    end else begin
                        do_text         = 1'b1;
                        text_char       = C_LT;
                        ws_seen_next    = 1'b0;
                        state_next      = S_TEXT;
                        hold_valid_next = 1'b1;
                        hold_char_next  = cur;
                    end
                end
                S_NAME: begin
                    if (cur_namech) begin
                        if (name_len_reg < MAX_LEN) begin
                            append = 1'b1;
                        end else begin
                            trunc_next = 1'b1;
                        end
                    end else if (cur_ws) begin
                        state_next = S_ATTR;
                    end else if (cur == C_GT) begin
                        do_tag     = 1'b1;
                        state_next = S_TEXT;
                    end else if (cur == C_SLASH) begin
                        state_next = S_ATTR;
                        slash_next = 1'b1;
                    end
                end
                S_ATTR: begin
                    if (cur == C_SLASH) begin
                        slash_next = 1'b1;
                    end else if (cur == C_GT) begin
                        do_tag     = 1'b1;
                        state_next = S_TEXT;
                    end else begin
                        slash_next = 1'b0;
                    end
                end
                S_SKIP: begin
                    if (cur == C_GT) begin
                        state_next = S_TEXT;
                    end
                end
                default: ;
            endcase
        end

        // End of input: any partially parsed tag is simply abandoned.
        if (active && in_done && !accept && !hold_valid_reg) begin
            state_next = S_FLUSH;
        end

        // END waits until the previous token has been taken.
        if ((state_reg == S_FLUSH) && (!tok_valid_reg || tok_ready)) begin
            do_end     = 1'b1;
            state_next = S_DONE;
        end

        if (append) begin
            for (int i = 0; i < MAX_TAG; i++) begin
                if (byte_sel[i]) begin
                    name_buf_next[i*8 +: 8] = cur_lc;
                end
            end
            name_len_next = name_len_reg + 4'd1;
        end

        if (do_text) begin
            tok_valid_next = 1'b1;
            tok_type_next  = T_TEXT;
            tok_char_next  = text_char;
            tag_name_next  = '0;
            tag_len_next   = 4'd0;
            tag_trunc_next = 1'b0;
            tag_self_next  = 1'b0;
        end

        // "</>" style closes with no name produce nothing.
        if (do_tag && !(close_reg && (name_len_reg == 4'd0))) begin
            tok_valid_next = 1'b1;
            tok_type_next  = close_reg ? T_CLOSE : T_OPEN;
            tok_char_next  = 8'h00;
            tag_name_next  = name_buf_reg;
            tag_len_next   = name_len_reg;
            tag_trunc_next = trunc_reg;
            tag_self_next  = slash_reg && !close_reg;
            ws_seen_next   = 1'b0;
        end

        if (do_end) begin
            tok_valid_next = 1'b1;
            tok_type_next  = T_END;
            tok_char_next  = 8'h00;
            tag_name_next  = '0;
            tag_len_next   = 4'd0;
            tag_trunc_next = 1'b0;
            tag_self_next  = 1'b0;
        end
    end

    // State and token registers; state_enable low clears everything at once.
    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            state_reg      <= S_TEXT;
            ws_seen_reg    <= 1'b0;
            close_reg      <= 1'b0;
            slash_reg      <= 1'b0;
            name_buf_reg   <= '0;
            name_len_reg   <= 4'd0;
            trunc_reg      <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_char_reg  <= 8'h00;
            tok_valid_reg  <= 1'b0;
            tok_type_reg   <= T_TEXT;
            tok_char_reg   <= 8'h00;
            tag_name_reg   <= '0;
            tag_len_reg    <= 4'd0;
            tag_trunc_reg  <= 1'b0;
            tag_self_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ws_seen_reg    <= ws_seen_next;
            close_reg      <= close_next;
            slash_reg      <= slash_next;
            name_buf_reg   <= name_buf_next;
            name_len_reg   <= name_len_next;
            trunc_reg      <= trunc_next;
            hold_valid_reg <= hold_valid_next;
            hold_char_reg  <= hold_char_next;
            tok_valid_reg  <= tok_valid_next;
            tok_type_reg   <= tok_type_next;
            tok_char_reg   <= tok_char_next;
            tag_name_reg   <= tag_name_next;
            tag_len_reg    <= tag_len_next;
            tag_trunc_reg  <= tag_trunc_next;
            tag_self_reg   <= tag_self_next;
        end
    end

    assign tok_valid = tok_valid_reg;
    assign tok_type  = tok_type_reg;
    assign tok_char  = tok_char_reg;
    assign tag_name  = tag_name_reg;
    assign tag_len   = tag_len_reg;
    assign tag_trunc = tag_trunc_reg;
    assign tag_self  = tag_self_reg;

endmodule

// File: tb/tb_html_tokenizer.sv
// Testbench for html_tokenizer: directed documents with hand-written expected
// tokens plus random documents checked against a string-level reference parser.
module tb_html_tokenizer;

    localparam int MT = 8;

    logic            clock = 1'b0;
    logic            state_enable;
    logic [7:0]      char;
    logic            char_valid;
    logic            char_ready;
    logic            in_done;
    logic            tok_valid;
    logic            tok_ready;
    logic [1:0]      tok_type;
    logic [7:0]      tok_char;
    logic [8*MT-1:0] tag_name;
    logic [3:0]      tag_len;
    logic            tag_trunc;
    logic            tag_self;

    always #5 clock = ~clock;

    html_tokenizer #(.MAX_TAG(MT)) dut (
        .clock       (clock),
        .state_enable(state_enable),
        .char        (char),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .in_done     (in_done),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .tok_type    (tok_type),
        .tok_char    (tok_char),
        .tag_name    (tag_name),
        .tag_len     (tag_len),
        .tag_trunc   (tag_trunc),
        .tag_self    (tag_self)
    );

    typedef struct packed {
        logic [1:0]      typ;
        logic [7:0]      ch;
        logic [8*MT-1:0] name;
        logic [3:0]      len;
        logic            trunc;
        logic            slf;
    } tok_t;

    tok_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   end_count = 0;
    int   rdy_mode  = 0;      // 0 always ready, 1 random, 2 manual_ready
    logic manual_ready = 1'b1;
    bit   gaps = 1'b0;

    function automatic string fmt(input tok_t t);
        return $sformatf("type=%0d char=%02h name=%016h len=%0d trunc=%0d self=%0d",
                         t.typ, t.ch, t.name, t.len, t.trunc, t.slf);
    endfunction

    task automatic check(input bit ok, input string nm, input string act, input string req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", nm, act, req);
        end
    endtask

    function automatic logic [8*MT-1:0] pack_name(input string s);
        logic [8*MT-1:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < MT; i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    task automatic exp_text(input logic [7:0] c);
        tok_t t;
        t = '0;
        t.ch = c;
        exp_q.push_back(t);
    endtask

    task automatic exp_tag(input bit cl, input string nm, input int ln, input bit tr, input bit sf);
        tok_t t;
        t = '0;
        t.typ   = cl ? 2'd2 : 2'd1;
        t.name  = pack_name(nm);
        t.len   = ln[3:0];
        t.trunc = tr;
        t.slf   = sf;
        exp_q.push_back(t);
    endtask

    task automatic exp_end();
        tok_t t;
        t = '0;
        t.typ = 2'd3;
        exp_q.push_back(t);
    endtask

    // ---------------- reference parser (whole-string view) ----------------
    function automatic bit is_ws(input logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
    endfunction
    function automatic bit is_letter(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction
    function automatic bit is_namech(input logic [7:0] c);
        return is_letter(c) || (c >= "0" && c <= "9") || c == "-";
    endfunction
    function automatic logic [7:0] lower(input logic [7:0] c);
        return (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    endfunction
    function automatic int find_gt(input logic [7:0] t[$], input int from);
        for (int k = from; k < t.size(); k++) if (t[k] == ">") return k;
        return -1;
    endfunction

    task automatic model_push(input logic [7:0] s[$]);
        logic [7:0] t[$];
        int i, n, gt, start, cnt;
        bit ws, cl, tr, sf, in_name;
        logic [8*MT-1:0] nm;
        tok_t tk;
        foreach (s[k]) if (!(s[k] == 8'h00 || s[k] == 8'hFF)) t.push_back(s[k]);
        n = t.size();
        i = 0;
        ws = 0;
        while (i < n) begin
            if (t[i] != "<") begin
                if (is_ws(t[i])) begin
                    if (!ws) exp_text(8'h20);
                    ws = 1;
                end else begin
                    exp_text(t[i]);
                    ws = 0;
                end
                i++;
            end else if (i + 1 >= n) begin
                i = n;
            end else if (t[i+1] == "!") begin
                gt = find_gt(t, i + 2);
                i = (gt < 0) ? n : gt + 1;
            end else if (t[i+1] == "/" || is_letter(t[i+1])) begin
                cl = (t[i+1] == "/");
                start = cl ? i + 2 : i + 1;
                gt = find_gt(t, start);
                if (gt < 0) begin
                    i = n;
                end else begin
                    nm = '0; cnt = 0; tr = 0; in_name = 1;
                    for (int k = start; k < gt; k++) begin
                        if (is_ws(t[k]) || t[k] == "/") in_name = 0;
                        else if (in_name && is_namech(t[k])) begin
                            if (cnt < MT) begin
                                nm[cnt*8 +: 8] = lower(t[k]);
                                cnt++;
                            end else tr = 1;
                        end
                    end
                    sf = !cl && gt > start && t[gt-1] == "/";
                    if (!(cl && cnt == 0)) begin
                        tk = '0;
                        tk.typ = cl ? 2'd2 : 2'd1;
                        tk.name = nm;
                        tk.len = 4'(cnt);
                        tk.trunc = tr;
                        tk.slf = sf;
                        exp_q.push_back(tk);
                        ws = 0;
                    end
                    i = gt + 1;
                end
            end else begin
                exp_text("<");
                ws = 0;
                i++;
            end
        end
        exp_end();
    endtask

    // ---------------- tok_ready driver ----------------
    initial tok_ready = 1'b1;
    always begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       tok_ready = 1'b1;
            1:       tok_ready = ($urandom_range(0, 3) != 0);
            default: tok_ready = manual_ready;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        tok_t a, e;
        if (state_enable === 1'b1 && tok_valid === 1'b1 && tok_ready === 1'b1) begin
            a.typ = tok_type; a.ch = tok_char; a.name = tag_name;
            a.len = tag_len; a.trunc = tag_trunc; a.slf = tag_self;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_token", fmt(a), "no token");
            end else begin
                e = exp_q.pop_front();
                check(a === e, "token", fmt(a), fmt(e));
            end
            if (tok_type == 2'd3) end_count++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_gap();
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    endtask

    task automatic send_byte(input logic [7:0] c);
        bit got;
        got = 0;
        char = c;
        char_valid = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            got = char_ready;
        end
        check(got, "accept_timeout", "not accepted", $sformatf("char %02h accepted", c));
        @(posedge clock); #1;
        char_valid = 1'b0;
        char = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            idle_gap();
            send_byte(s[i]);
        end
    endtask

    task automatic do_reset();
        state_enable = 1'b0;
        char_valid = 1'b0;
        char = 8'h00;
        in_done = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        state_enable = 1'b1;
    endtask

    task automatic finish_doc(input string nm);
        int start;
        bit got, all0;
        start = end_count;
        got = 0;
        in_done = 1'b1;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clock);
            got = (end_count != start);
        end
        check(got, {nm, "_end"}, "END not seen", "END token");
        check(exp_q.size() == 0, {nm, "_drained"}, $sformatf("%0d left", exp_q.size()), "0 left");
        all0 = 1;
        repeat (3) begin
            @(negedge clock);
            if (char_ready !== 1'b0) all0 = 0;
        end
        check(all0, {nm, "_ready_after_end"}, "char_ready 1", "char_ready 0");
        @(posedge clock); #1;
    endtask

    task automatic run_directed(input string s, input string nm);
        send_str(s);
        finish_doc(nm);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int r, len;
        state_enable = 1'b0;
        char = 8'h00;
        char_valid = 1'b0;
        in_done = 1'b0;
        #3;
        check(tok_valid === 0 && tok_type === 0 && tok_char === 0 && tag_name === 0 &&
              tag_len === 0 && tag_trunc === 0 && tag_self === 0 && char_ready === 0,
              "reset_outputs",
              $sformatf("v=%b t=%0d c=%02h n=%h l=%0d tr=%b s=%b rdy=%b", tok_valid, tok_type,
                        tok_char, tag_name, tag_len, tag_trunc, tag_self, char_ready),
              "all zero");

        // Directed documents
        rdy_mode = 0;
        do_reset();
        exp_tag(0, "p", 1, 0, 0); exp_text("h"); exp_text("i"); exp_tag(1, "p", 1, 0, 0); exp_end();
        run_directed("<P>hi</p>", "p_hi");

        do_reset();
        exp_text("a"); exp_text(8'h20); exp_text("b"); exp_end();
        send_byte("a");
        send_byte(8'h20);
        send_byte(8'h0A);
        send_byte(8'h09);
        send_byte(8'h20);
        send_byte("b");
        finish_doc("ws_collapse");

        do_reset();
        exp_tag(0, "div", 3, 0, 1); exp_end();
        run_directed("<DIV class=x/>", "div_self");

        do_reset();
        exp_tag(0, "br", 2, 0, 1); exp_end();
        run_directed("<br />", "br_self");

        do_reset();
        exp_tag(0, "a", 1, 0, 0); exp_end();
        run_directed("<a/b>", "a_not_self");

        do_reset();
        exp_tag(0, "verylong", 8, 1, 0); exp_end();
        run_directed("<VeryLongTagName>", "trunc");

        do_reset();
        exp_text("a"); exp_end();
        run_directed("<!DOCTYPE html>a", "doctype");

        do_reset();
        exp_text("a"); exp_text("<"); exp_text("3"); exp_end();
        run_directed("a<3", "lt_text");

        do_reset();
        exp_tag(1, "x", 1, 0, 0); exp_end();
        send_str("</>");
        send_byte(8'h00);
        send_str("</x");
        send_byte(8'hFF);
        send_byte(">");
        finish_doc("empty_close");

        // Backpressure: 'x' must stay put while tok_ready is low
        rdy_mode = 2;
        manual_ready = 1'b0;
        do_reset();
        exp_text("x"); exp_text("y"); exp_end();
        char = "x";
        char_valid = 1'b1;
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clock);
                got = char_ready;
            end
            check(got, "bp_accept_x", "not accepted", "accepted");
        end
        @(posedge clock); #1;
        char = "y";
        repeat (5) begin
            @(negedge clock);
            check(tok_valid === 1 && tok_type === 0 && tok_char === "x" && tag_len === 0 &&
                  char_ready === 0 && tok_ready === 0, "bp_hold",
                  $sformatf("v=%b t=%0d c=%02h rdy=%b", tok_valid, tok_type, tok_char, char_ready),
                  "v=1 t=0 c=78 rdy=0");
        end
        manual_ready = 1'b1;
        send_byte("y");
        finish_doc("backpressure");
        rdy_mode = 0;

        // Reset in the middle of a tag
        do_reset();
        send_str("<ta");
        state_enable = 1'b0;
        #1;
        check(tok_valid === 0 && tok_type === 0 && tok_char === 0 && tag_name === 0 &&
              tag_len === 0 && tag_trunc === 0 && tag_self === 0 && char_ready === 0,
              "midtag_reset_outputs",
              $sformatf("v=%b t=%0d c=%02h n=%h rdy=%b", tok_valid, tok_type, tok_char,
                        tag_name, char_ready), "all zero");
        @(posedge clock); #1;
        state_enable = 1'b1;
        exp_text("b"); exp_end();
        run_directed("b", "after_reset");

        // Random documents against the reference parser
        rdy_mode = 1;
        gaps = 1'b1;
        for (int t = 0; t < 40; t++) begin
            do_reset();
            q.delete();
            len = $urandom_range(5, 30);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 99);
                if (r < 12)      q.push_back("<");
                else if (r < 20) q.push_back(">");
                else if (r < 25) q.push_back("/");
                else if (r < 28) q.push_back("!");
                else if (r < 36) begin
                    case ($urandom_range(0, 3))
                        0: q.push_back(8'h20);
                        1: q.push_back(8'h09);
                        2: q.push_back(8'h0A);
                        default: q.push_back(8'h0D);
                    endcase
                end
                else if (r < 38) q.push_back($urandom_range(0, 1) ? 8'hFF : 8'h00);
                else if (r < 44) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                else if (r < 47) q.push_back("-");
                else if (r < 50) q.push_back("=");
                else if (r < 80) q.push_back(8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + $urandom_range(0, 25)));
                else             q.push_back(8'($urandom_range(33, 126)));
            end
            model_push(q);
            foreach (q[i]) begin
                idle_gap();
                send_byte(q[i]);
            end
            finish_doc($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
